// File: rtl/mips32_pipeline.sv
// Five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB) with a unified
// word-addressed memory, EX-stage forwarding and branch resolution in EX.
module mips32_pipeline #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] Mem [0:MEM_DEPTH-1];
  logic [31:0] Reg [0:31];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        fetch_stop;

  logic        if_id_valid;
  logic [31:0] if_id_ir, if_id_npc;

  logic        id_ex_valid, id_ex_wr;
  logic [5:0]  id_ex_op;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

  logic        ex_mem_wr, ex_mem_load, ex_mem_store, ex_mem_halt;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_alu, ex_mem_b;

  logic        mem_wb_wr, mem_wb_halt;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_val;

  // ID decode
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_rr, id_rm, id_wr, id_hlt, wb_we;

  assign id_op  = if_id_ir[31:26];
  assign id_rs  = if_id_ir[25:21];
  assign id_rt  = if_id_ir[20:16];
  assign id_rd  = if_id_ir[15:11];
  assign id_imm = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign id_rr  = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
  assign id_rm  = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  assign id_wr  = if_id_valid && (id_rr || id_rm || id_op == OP_LW);
  assign id_dest = id_rr ? id_rd : id_rt;
  assign id_hlt = if_id_valid && id_op == OP_HLT;
  assign wb_we  = mem_wb_wr && mem_wb_dest != 5'd0 && !HALTED;

  // Register read with write-through from the instruction retiring this cycle
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != 5'd0) id_a = (wb_we && mem_wb_dest == id_rs) ? mem_wb_val : Reg[id_rs];
    if (id_rt != 5'd0) id_b = (wb_we && mem_wb_dest == id_rt) ? mem_wb_val : Reg[id_rt];
  end

  // EX forwarding: EX/MEM is younger than MEM/WB, so it is checked first
  logic [31:0] fwd_a, fwd_b, alu_out, br_target;
  logic        ex_fwd_ok, wb_fwd_ok, taken;

  assign ex_fwd_ok = ex_mem_wr && ex_mem_dest != 5'd0;
  assign wb_fwd_ok = mem_wb_wr && mem_wb_dest != 5'd0;

  always_comb begin
    fwd_a = id_ex_a;
    fwd_b = id_ex_b;
    if (ex_fwd_ok && ex_mem_dest == id_ex_rs)      fwd_a = ex_mem_alu;
    else if (wb_fwd_ok && mem_wb_dest == id_ex_rs) fwd_a = mem_wb_val;
    if (ex_fwd_ok && ex_mem_dest == id_ex_rt)      fwd_b = ex_mem_alu;
    else if (wb_fwd_ok && mem_wb_dest == id_ex_rt) fwd_b = mem_wb_val;
  end

  always_comb begin
    alu_out = '0;
    case (id_ex_op)
      OP_ADD:                alu_out = fwd_a + fwd_b;
      OP_SUB:                alu_out = fwd_a - fwd_b;
      OP_AND:                alu_out = fwd_a & fwd_b;
      OP_OR:                 alu_out = fwd_a | fwd_b;
      OP_SLT:                alu_out = {31'b0, $signed(fwd_a) < $signed(fwd_b)};
      OP_MUL:                alu_out = fwd_a * fwd_b;
      OP_ADDI, OP_LW, OP_SW: alu_out = fwd_a + id_ex_imm;
      OP_SUBI:               alu_out = fwd_a - id_ex_imm;
      OP_SLTI:               alu_out = {31'b0, $signed(fwd_a) < $signed(id_ex_imm)};
      default:               alu_out = '0;
    endcase
  end

  assign taken = id_ex_valid &&
                 ((id_ex_op == OP_BNEQZ && fwd_a != '0) ||
                  (id_ex_op == OP_BEQZ  && fwd_a == '0));
  assign br_target = id_ex_npc + id_ex_imm;

  logic [31:0] lmd;
  assign lmd = Mem[ex_mem_alu[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      fetch_stop   <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_ir     <= '0;
      if_id_npc    <= '0;
      id_ex_valid  <= 1'b0;
      id_ex_wr     <= 1'b0;
      id_ex_op     <= '0;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_dest   <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      id_ex_imm    <= '0;
      id_ex_npc    <= '0;
      ex_mem_wr    <= 1'b0;
      ex_mem_load  <= 1'b0;
      ex_mem_store <= 1'b0;
      ex_mem_halt  <= 1'b0;
      ex_mem_dest  <= '0;
      ex_mem_alu   <= '0;
      ex_mem_b     <= '0;
      mem_wb_wr    <= 1'b0;
      mem_wb_halt  <= 1'b0;
      mem_wb_dest  <= '0;
      mem_wb_val   <= '0;
    end else begin
      TAKEN_BRANCH <= taken;
      HALTED       <= HALTED | mem_wb_halt;
      // A taken branch in EX is older than an HLT in ID, so it wins
      fetch_stop   <= fetch_stop | (id_hlt && !taken);

      if (taken) begin
        PC          <= br_target;
        if_id_valid <= 1'b0;
      end else if (fetch_stop || id_hlt) begin
        if_id_valid <= 1'b0;
      end else begin
        if_id_ir    <= Mem[PC[ADDR_W-1:0]];
        if_id_npc   <= PC + 32'd1;
        PC          <= PC + 32'd1;
        if_id_valid <= 1'b1;
      end

      id_ex_valid <= if_id_valid && !taken;
      id_ex_wr    <= id_wr;
      id_ex_op    <= id_op;
      id_ex_rs    <= id_rs;
      id_ex_rt    <= id_rt;
      id_ex_dest  <= id_dest;
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_imm   <= id_imm;
      id_ex_npc   <= if_id_npc;

      ex_mem_wr    <= id_ex_valid && id_ex_wr;
      ex_mem_load  <= id_ex_valid && id_ex_op == OP_LW;
      ex_mem_store <= id_ex_valid && id_ex_op == OP_SW;
      ex_mem_halt  <= id_ex_valid && id_ex_op == OP_HLT;
      ex_mem_dest  <= id_ex_dest;
      ex_mem_alu   <= alu_out;
      ex_mem_b     <= fwd_b;

      mem_wb_wr   <= ex_mem_wr;
      mem_wb_halt <= ex_mem_halt;
      mem_wb_dest <= ex_mem_dest;
      mem_wb_val  <= ex_mem_load ? lmd : ex_mem_alu;
    end
  end

  // Architectural storage is not reset so preloaded contents survive rst_n
  always_ff @(posedge clk) begin
    if (ex_mem_store && !HALTED) Mem[ex_mem_alu[ADDR_W-1:0]] <= ex_mem_b;
  end

  always_ff @(posedge clk) begin
    if (wb_we) Reg[mem_wb_dest] <= mem_wb_val;
  end

  assign halted = HALTED;

endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed-program bench for mips32_pipeline: expectations are queued per program
// and checked against architectural state when halted rises.
module tb_mips32_pipeline;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic halted;

  mips32_pipeline dut (.clk(clk), .rst_n(rst_n), .halted(halted));

  always #5 clk = ~clk;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101;
  localparam logic [5:0] SW = 6'b001001, ADDI = 6'b001010;
  localparam logic [5:0] SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101;
  localparam logic [31:0] HLT = 32'hfc000000;

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_TAKEN = 3;

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int drains = 0;
  int taken_cnt = 0;
  bit prev_halted = 1'b0;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual_of(exp_t e);
    case (e.kind)
      K_REG:   return dut.Reg[e.idx];
      K_MEM:   return dut.Mem[e.idx];
      K_PC:    return dut.PC;
      default: return taken_cnt;
    endcase
  endfunction

  task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Monitor: on each rising edge of halted, compare every queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (halted && !prev_halted) begin
        while (sb.size() > 0) begin
          e = sb.pop_front();
          check(e.name, actual_of(e), e.val);
        end
        drains++;
      end
      prev_halted = halted;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dut.TAKEN_BRANCH) taken_cnt++;
    end
  end

  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) dut.Mem[i] = 32'h0;
    taken_cnt = 0;
  endtask

  task automatic run(input int budget, input string name);
    int start;
    start = drains;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < budget && drains == start; c++) @(posedge clk);
    #1;
    if (drains == start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: halted=%0b after %0d cycles, expected 1", name, halted, budget);
      sb.delete();
    end
  endtask

  task automatic load_prog1();
    dut.Mem[0] = 32'h28010078;
    dut.Mem[1] = 32'h0ce77800;
    dut.Mem[2] = 32'h20220000;
    dut.Mem[3] = 32'h0ce77800;
    dut.Mem[4] = 32'h2842002d;
    dut.Mem[5] = 32'h0ce77800;
    dut.Mem[6] = 32'h24220001;
    dut.Mem[7] = 32'h00000000;
    dut.Mem[8] = 32'hfc000000;
    dut.Mem[120] = 32'd85;
    dut.Mem[121] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = k;
  endtask

  task automatic expect_prog1(input string t);
    expect_val({t, "_mem121"}, K_MEM, 121, 32'd130);
    expect_val({t, "_mem120"}, K_MEM, 120, 32'd85);
    expect_val({t, "_r1"},     K_REG, 1,   32'd120);
    expect_val({t, "_r2"},     K_REG, 2,   32'd130);
    expect_val({t, "_r15"},    K_REG, 15,  32'd7);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc", dut.PC, 32'd0);
    check("reset_halted", {31'b0, halted}, 32'd0);

    // Load / add / store
    begin_test();
    load_prog1();
    expect_prog1("t1");
    run(20, "t1");

    // Back-to-back dependencies through both forwarding paths
    begin_test();
    for (int k = 0; k < 32; k++) dut.Reg[k] = (k == 0) ? 32'h0 : 32'haaaa;
    dut.Mem[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd10);
    dut.Mem[1] = enc_r(ADD, 5'd1, 5'd1, 5'd2);
    dut.Mem[2] = enc_r(SUB, 5'd2, 5'd1, 5'd3);
    dut.Mem[3] = HLT;
    expect_val("t2_r1", K_REG, 1, 32'd10);
    expect_val("t2_r2", K_REG, 2, 32'd20);
    expect_val("t2_r3", K_REG, 3, 32'd10);
    run(40, "t2");

    // BNEQZ loop; addr 4 would corrupt R2 if the IF/ID slot were not flushed
    begin_test();
    dut.Reg[1] = 32'd3;
    dut.Reg[2] = 32'd0;
    dut.Mem[0] = enc_i(ADDI, 5'd2, 5'd2, 16'd5);
    dut.Mem[1] = enc_i(SUBI, 5'd1, 5'd1, 16'd1);
    dut.Mem[2] = enc_i(BNEQZ, 5'd1, 5'd0, 16'hfffd);
    dut.Mem[3] = HLT;
    dut.Mem[4] = enc_i(ADDI, 5'd2, 5'd2, 16'd100);
    expect_val("t3_r2", K_REG, 2, 32'd15);
    expect_val("t3_r1", K_REG, 1, 32'd0);
    expect_val("t3_taken", K_TAKEN, 0, 32'd2);
    expect_val("t3_pc", K_PC, 0, 32'd4);
    run(80, "t3");

    // MUL / SLT / SLTI / AND with a negative operand
    begin_test();
    dut.Reg[1] = 32'hfffffffc;
    dut.Reg[2] = 32'd6;
    for (int k = 3; k < 8; k++) dut.Reg[k] = 32'h55;
    dut.Mem[0] = enc_r(MUL, 5'd1, 5'd2, 5'd3);
    dut.Mem[1] = enc_r(SLT, 5'd1, 5'd2, 5'd4);
    dut.Mem[2] = enc_i(SLTI, 5'd2, 5'd5, 16'd5);
    dut.Mem[3] = enc_r(AND_, 5'd1, 5'd2, 5'd6);
    dut.Mem[4] = enc_r(SLT, 5'd2, 5'd1, 5'd7);
    dut.Mem[5] = HLT;
    expect_val("t4_mul",  K_REG, 3, 32'hffffffe8);
    expect_val("t4_slt",  K_REG, 4, 32'd1);
    expect_val("t4_slti", K_REG, 5, 32'd0);
    expect_val("t4_and",  K_REG, 6, 32'd4);
    expect_val("t4_slt2", K_REG, 7, 32'd0);
    run(40, "t4");

    // R0 protection (including no forwarding of R0) and nothing after HLT
    begin_test();
    dut.Reg[0] = 32'h0;
    dut.Reg[1] = 32'h12345678;
    dut.Reg[8] = 32'h99;
    dut.Mem[50] = 32'hdeadbeef;
    dut.Mem[0] = enc_i(ADDI, 5'd0, 5'd0, 16'd7);
    dut.Mem[1] = enc_r(ADD, 5'd0, 5'd0, 5'd8);
    dut.Mem[2] = HLT;
    dut.Mem[3] = enc_i(SW, 5'd0, 5'd1, 16'd50);
    expect_val("t5_r0", K_REG, 0, 32'd0);
    expect_val("t5_r8", K_REG, 8, 32'd0);
    expect_val("t5_mem50", K_MEM, 50, 32'hdeadbeef);
    expect_val("t5_pc", K_PC, 0, 32'd3);
    run(40, "t5");
    repeat (5) @(negedge clk);
    check("t5_pc_frozen", dut.PC, 32'd3);
    check("t5_mem50_later", dut.Mem[50], 32'hdeadbeef);
    check("t5_halted_sticky", {31'b0, halted}, 32'd1);

    // Asynchronous reset in the middle of the load/add/store program
    begin_test();
    load_prog1();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_reset_pc", dut.PC, 32'd0);
    check("t6_reset_HALTED", {31'b0, dut.HALTED}, 32'd0);
    check("t6_reset_halted", {31'b0, halted}, 32'd0);
    expect_prog1("t6");
    run(30, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
